// File: rtl/mema_pkg.sv
// Shared definitions for the memA load/stream controller.
//   ctrl_state_t : sequencer states
//   elem_t       : one signed A-operand element at the default width
//   DEF_*        : default array geometry
package mema_pkg;

    localparam int DEF_BITS_AB = 8;
    localparam int DEF_DIM     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } ctrl_state_t;

    typedef logic signed [DEF_BITS_AB-1:0] elem_t;

endpackage

// File: rtl/seq_counter.sv
// Up-counter with synchronous clear, enable and terminal-count flag.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return to zero (dominates en)
//   en       : advance by one; wraps to zero after TC
//   cnt      : current count
//   tc       : cnt == TC
module seq_counter #(
    parameter int TC = 7,
    parameter int W  = (TC > 0) ? $clog2(TC + 1) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(TC));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/mema_load_ctrl.sv
// memA load/stream sequencer: accepts DIM rows over valid/ready, writes them
// into memA in acceptance order, then holds mem_en for STREAM_LEN cycles and
// pulses done.
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : begin / cancel a sequence
//   in_valid/in_ready : row handshake, in_row carries the row
//   mem_wren/mem_row/mem_ain : registered memA write port
//   mem_en            : registered memA read/shift enable
//   busy, done        : sequence in progress / one-cycle completion pulse
module mema_load_ctrl
    import mema_pkg::*;
#(
    parameter int BITS_AB    = DEF_BITS_AB,
    parameter int DIM        = DEF_DIM,
    parameter int STREAM_LEN = 2 * DIM
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [BITS_AB-1:0] in_row [DIM],
    output logic                      mem_wren,
    output logic [$clog2(DIM)-1:0]    mem_row,
    output logic signed [BITS_AB-1:0] mem_ain [DIM],
    output logic                      mem_en,
    output logic                      busy,
    output logic                      done
);

    localparam int RW = $clog2(DIM);
    localparam int SW = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;

    ctrl_state_t state, state_nxt;

    logic          hs;
    logic          cnt_clr;
    logic [RW-1:0] row_cnt;
    logic          row_tc;
    logic [SW-1:0] stream_cnt;
    logic          stream_tc;

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign hs       = in_valid && in_ready;

    // Counters sit at zero whenever no sequence is live, so a fresh start
    // always begins at row 0 / stream position 0.
    assign cnt_clr  = (state == IDLE) || (abort && busy);

    seq_counter #(.TC(DIM - 1), .W(RW)) u_row_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (hs),
        .cnt (row_cnt),
        .tc  (row_tc)
    );

    seq_counter #(.TC(STREAM_LEN - 1), .W(SW)) u_stream_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (mem_en),
        .cnt (stream_cnt),
        .tc  (stream_tc)
    );

    // Stream position is only consumed through its terminal count.
    logic unused_stream_cnt;
    assign unused_stream_cnt = ^stream_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // STREAM ends on the first cycle with neither the final write nor the
    // enable window active, which lands one cycle after the last mem_en.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start && !abort) state_nxt = LOAD;
            LOAD: begin
                if (abort)                state_nxt = IDLE;
                else if (hs && row_tc)    state_nxt = STREAM;
            end
            STREAM: begin
                if (abort)                      state_nxt = IDLE;
                else if (!mem_wren && !mem_en)  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wren <= 1'b0;
            mem_row  <= '0;
            mem_en   <= 1'b0;
            for (int j = 0; j < DIM; j++) mem_ain[j] <= '0;
        end else begin
            mem_wren <= hs && !abort;
            if (hs && !abort) begin
                mem_row <= row_cnt;
                mem_ain <= in_row;
            end
            // The final row write (first STREAM cycle) arms the window; it
            // then runs until the stream counter reaches its terminal count.
            mem_en <= (state == STREAM) && !abort &&
                      (mem_wren || (mem_en && !stream_tc));
        end
    end

endmodule
